// File: rtl/acc_drain_pkg.sv
// ============================================================================
// Module   : acc_drain_pkg
// Brief    : Shared types and helpers for the accumulator drain sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package acc_drain_pkg;

    localparam int c_DATA_W     = 8;
    localparam int c_REG_ADDR_W = 4;
    localparam int c_MEM_ADDR_W = 8;

    typedef enum logic [1:0] {
        DEST_REG  = 2'b00,
        DEST_MEM  = 2'b01,
        DEST_BOTH = 2'b10,
        DEST_NONE = 2'b11
    } dest_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REG_WR  = 2'd1,
        ST_MEM_REQ = 2'd2,
        ST_DONE    = 2'd3
    } drain_state_t;

    // Counter width able to hold 0..limit; never narrower than one bit.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/acc_drain_if.sv
// ============================================================================
// Module   : acc_drain_if
// Brief    : Accumulator-in / register-file / data-memory bundle of acc_drain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface acc_drain_if;
    import acc_drain_pkg::*;

    logic [c_DATA_W-1:0]     acc_in;
    logic                    start;
    logic [1:0]              dest_ctrl;
    logic [c_REG_ADDR_W-1:0] reg_addr_in;
    logic [c_MEM_ADDR_W-1:0] mem_addr_in;

    logic                    reg_write_en;
    logic [c_REG_ADDR_W-1:0] reg_write_addr;
    logic [c_DATA_W-1:0]     reg_write_data;

    logic                    mem_req;
    logic [c_MEM_ADDR_W-1:0] mem_addr;
    logic [c_DATA_W-1:0]     mem_wdata;
    logic                    mem_ack;

    logic                    busy;
    logic                    done;
    logic                    timeout_err;

    modport master (
        output acc_in, start, dest_ctrl, reg_addr_in, mem_addr_in, mem_ack,
        input  reg_write_en, reg_write_addr, reg_write_data,
               mem_req, mem_addr, mem_wdata, busy, done, timeout_err
    );

    modport slave (
        input  acc_in, start, dest_ctrl, reg_addr_in, mem_addr_in, mem_ack,
        output reg_write_en, reg_write_addr, reg_write_data,
               mem_req, mem_addr, mem_wdata, busy, done, timeout_err
    );

endinterface

`default_nettype wire

// File: rtl/acc_drain_wait_counter.sv
// ============================================================================
// Module   : wait_counter
// Brief    : Saturating up-counter with synchronous clear and limit flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wait_counter #(
    parameter int WIDTH = 4,
    parameter int LIMIT = 15
) (
    input  wire logic CLK,
    input  wire logic RESET,
    input  wire logic i_clr,
    input  wire logic i_en,
    output logic      o_at_limit
);

    localparam logic [WIDTH-1:0] c_LIMIT = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] c_ONE   = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge CLK) begin
        if (RESET || i_clr) begin
            r_count <= '0;
        end else if (i_en && !o_at_limit) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign o_at_limit = (r_count == c_LIMIT);

endmodule

`default_nettype wire

// File: rtl/acc_drain.sv
// ============================================================================
// Module   : acc_drain
// Brief    : Snapshots the accumulator and drains it to register file and/or
//            data memory, stalling fetch while in flight.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module acc_drain
    import acc_drain_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  wire logic  CLK,
    input  wire logic  RESET,
    acc_drain_if.slave bus
);

    localparam int c_CNT_W = cnt_width(MEM_TIMEOUT);

    drain_state_t            r_state;
    drain_state_t            w_next_state;
    dest_t                   r_dest;
    logic [c_DATA_W-1:0]     r_acc;
    logic [c_REG_ADDR_W-1:0] r_reg_addr;
    logic [c_MEM_ADDR_W-1:0] r_mem_addr;
    logic                    r_timeout_err;

    logic w_accept;
    logic w_at_limit;
    logic w_timeout;

    assign w_accept  = (r_state == ST_IDLE) && bus.start;
    // An ack on the limit cycle wins over the timeout.
    assign w_timeout = (r_state == ST_MEM_REQ) && w_at_limit && !bus.mem_ack;

    wait_counter #(
        .WIDTH (c_CNT_W),
        .LIMIT (MEM_TIMEOUT)
    ) u_wait_counter (
        .CLK        (CLK),
        .RESET      (RESET),
        .i_clr      (r_state != ST_MEM_REQ),
        .i_en       (1'b1),
        .o_at_limit (w_at_limit)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    case (dest_t'(bus.dest_ctrl))
                        DEST_REG, DEST_BOTH: w_next_state = ST_REG_WR;
                        DEST_MEM:            w_next_state = ST_MEM_REQ;
                        default:             w_next_state = ST_DONE;
                    endcase
                end
            end
            ST_REG_WR: begin
                w_next_state = (r_dest == DEST_BOTH) ? ST_MEM_REQ : ST_DONE;
            end
            ST_MEM_REQ: begin
                if (bus.mem_ack || w_at_limit) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.reg_write_en = 1'b0;
        bus.mem_req      = 1'b0;
        bus.done         = 1'b0;
        bus.busy         = 1'b1;
        case (r_state)
            ST_IDLE:    bus.busy         = 1'b0;
            ST_REG_WR:  bus.reg_write_en = 1'b1;
            ST_MEM_REQ: bus.mem_req      = 1'b1;
            ST_DONE:    bus.done         = 1'b1;
            default:    bus.busy         = 1'b0;
        endcase
    end

    // Snapshot is taken only on an accepted start, so the inputs are free
    // to move while a drain is in flight.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_acc      <= '0;
            r_reg_addr <= '0;
            r_mem_addr <= '0;
            r_dest     <= DEST_REG;
        end else if (w_accept) begin
            r_acc      <= bus.acc_in;
            r_reg_addr <= bus.reg_addr_in;
            r_mem_addr <= bus.mem_addr_in;
            r_dest     <= dest_t'(bus.dest_ctrl);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET || w_accept) begin
            r_timeout_err <= 1'b0;
        end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
        end
    end

    assign bus.reg_write_addr = r_reg_addr;
    assign bus.reg_write_data = r_acc;
    assign bus.mem_addr       = r_mem_addr;
    assign bus.mem_wdata      = r_acc;
    assign bus.timeout_err    = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_acc_drain.sv
// ============================================================================
// Module   : tb_acc_drain
// Brief    : Directed vector bench for acc_drain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_acc_drain;

    typedef struct packed {
        logic       rst;
        logic       start;
        logic [1:0] dest;
        logic [7:0] acc;
        logic [3:0] raddr;
        logic [7:0] maddr;
        logic       ack;
    } in_t;

    typedef struct packed {
        logic       rwe;
        logic [3:0] rwa;
        logic [7:0] rwd;
        logic       mreq;
        logic [7:0] ma;
        logic [7:0] md;
        logic       busy;
        logic       done;
        logic       terr;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    localparam int c_NVEC = 17;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   n;
    vec_t vecs [c_NVEC];

    acc_drain_if bus ();

    acc_drain #(
        .MEM_TIMEOUT (15)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t vi(input logic r, input logic s, input logic [1:0] d,
                               input logic [7:0] a, input logic [3:0] ra,
                               input logic [7:0] ma, input logic k);
        in_t v;
        v.rst = r; v.start = s; v.dest = d; v.acc = a;
        v.raddr = ra; v.maddr = ma; v.ack = k;
        return v;
    endfunction

    function automatic out_t vo(input logic rwe, input logic [3:0] rwa, input logic [7:0] rwd,
                                input logic mreq, input logic [7:0] ma, input logic [7:0] md,
                                input logic busy, input logic done, input logic terr);
        out_t v;
        v.rwe = rwe; v.rwa = rwa; v.rwd = rwd; v.mreq = mreq; v.ma = ma; v.md = md;
        v.busy = busy; v.done = done; v.terr = terr;
        return v;
    endfunction

    function automatic out_t get_out();
        return vo(bus.reg_write_en, bus.reg_write_addr, bus.reg_write_data,
                  bus.mem_req, bus.mem_addr, bus.mem_wdata,
                  bus.busy, bus.done, bus.timeout_err);
    endfunction

    task automatic drive(input in_t v);
        rst             = v.rst;
        bus.start       = v.start;
        bus.dest_ctrl   = v.dest;
        bus.acc_in      = v.acc;
        bus.reg_addr_in = v.raddr;
        bus.mem_addr_in = v.maddr;
        bus.mem_ack     = v.ack;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;

        // Reset, register-only path.
        vecs[0]  = '{i: vi(1, 0, 2'b00, 8'h00, 4'h0, 8'h00, 0), o: vo(0, 4'h0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0)};
        vecs[1]  = '{i: vi(0, 1, 2'b00, 8'h5A, 4'h3, 8'h77, 0), o: vo(1, 4'h3, 8'h5A, 0, 8'h77, 8'h5A, 1, 0, 0)};
        vecs[2]  = '{i: vi(0, 0, 2'b00, 8'h00, 4'h0, 8'h00, 0), o: vo(0, 4'h3, 8'h5A, 0, 8'h77, 8'h5A, 1, 1, 0)};
        vecs[3]  = '{i: vi(0, 0, 2'b00, 8'h00, 4'h0, 8'h00, 0), o: vo(0, 4'h3, 8'h5A, 0, 8'h77, 8'h5A, 0, 0, 0)};
        // Memory path with inputs changing under an in-flight drain.
        vecs[4]  = '{i: vi(0, 1, 2'b01, 8'hC3, 4'h0, 8'h40, 0), o: vo(0, 4'h0, 8'hC3, 1, 8'h40, 8'hC3, 1, 0, 0)};
        vecs[5]  = '{i: vi(0, 0, 2'b01, 8'hFF, 4'hF, 8'hFF, 0), o: vo(0, 4'h0, 8'hC3, 1, 8'h40, 8'hC3, 1, 0, 0)};
        vecs[6]  = '{i: vi(0, 0, 2'b01, 8'hFF, 4'hF, 8'hFF, 0), o: vo(0, 4'h0, 8'hC3, 1, 8'h40, 8'hC3, 1, 0, 0)};
        vecs[7]  = '{i: vi(0, 0, 2'b01, 8'hFF, 4'hF, 8'hFF, 0), o: vo(0, 4'h0, 8'hC3, 1, 8'h40, 8'hC3, 1, 0, 0)};
        vecs[8]  = '{i: vi(0, 0, 2'b01, 8'hFF, 4'hF, 8'hFF, 1), o: vo(0, 4'h0, 8'hC3, 0, 8'h40, 8'hC3, 1, 1, 0)};
        // Start during DONE must be ignored.
        vecs[9]  = '{i: vi(0, 1, 2'b00, 8'hAA, 4'h7, 8'hBB, 0), o: vo(0, 4'h0, 8'hC3, 0, 8'h40, 8'hC3, 0, 0, 0)};
        // Register then memory, immediate ack.
        vecs[10] = '{i: vi(0, 1, 2'b10, 8'h11, 4'h5, 8'h22, 0), o: vo(1, 4'h5, 8'h11, 0, 8'h22, 8'h11, 1, 0, 0)};
        vecs[11] = '{i: vi(0, 0, 2'b10, 8'h00, 4'h0, 8'h00, 0), o: vo(0, 4'h5, 8'h11, 1, 8'h22, 8'h11, 1, 0, 0)};
        vecs[12] = '{i: vi(0, 0, 2'b10, 8'h00, 4'h0, 8'h00, 1), o: vo(0, 4'h5, 8'h11, 0, 8'h22, 8'h11, 1, 1, 0)};
        vecs[13] = '{i: vi(0, 0, 2'b00, 8'h00, 4'h0, 8'h00, 0), o: vo(0, 4'h5, 8'h11, 0, 8'h22, 8'h11, 0, 0, 0)};
        // No destination, then a stray ack in IDLE.
        vecs[14] = '{i: vi(0, 1, 2'b11, 8'h99, 4'h1, 8'h33, 0), o: vo(0, 4'h1, 8'h99, 0, 8'h33, 8'h99, 1, 1, 0)};
        vecs[15] = '{i: vi(0, 0, 2'b00, 8'h00, 4'h0, 8'h00, 1), o: vo(0, 4'h1, 8'h99, 0, 8'h33, 8'h99, 0, 0, 0)};
        vecs[16] = '{i: vi(0, 0, 2'b00, 8'h00, 4'h0, 8'h00, 0), o: vo(0, 4'h1, 8'h99, 0, 8'h33, 8'h99, 0, 0, 0)};

        for (int i = 0; i < c_NVEC; i++) begin
            drive(vecs[i].i);
            @(negedge clk);
            check($sformatf("vec%0d", i), 64'(get_out()), 64'(vecs[i].o));
        end

        // Timeout: 16 request cycles, then done with the sticky error.
        drive(vi(0, 1, 2'b01, 8'h3C, 4'h2, 8'hA0, 0));
        @(negedge clk);
        drive(vi(0, 0, 2'b00, 8'h00, 4'h0, 8'h00, 0));
        n = 0;
        while (bus.mem_req === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("timeout_req_cycles", 64'(n), 64'd16);
        check("timeout_done_err", 64'({bus.done, bus.timeout_err}), 64'(2'b11));
        @(negedge clk);
        check("timeout_err_sticky", 64'({bus.busy, bus.timeout_err}), 64'(2'b01));
        drive(vi(0, 1, 2'b11, 8'h00, 4'h0, 8'h00, 0));
        @(negedge clk);
        drive(vi(0, 0, 2'b00, 8'h00, 4'h0, 8'h00, 0));
        check("timeout_err_cleared", 64'({bus.done, bus.timeout_err}), 64'(2'b10));
        @(negedge clk);

        // Ack on the exact limit cycle is a success.
        drive(vi(0, 1, 2'b01, 8'h6D, 4'h0, 8'h12, 0));
        @(negedge clk);
        drive(vi(0, 0, 2'b00, 8'h00, 4'h0, 8'h00, 0));
        for (int k = 0; k < 15; k++) @(negedge clk);
        check("boundary_req_held", 64'(bus.mem_req), 64'd1);
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check("boundary_done_no_err", 64'({bus.mem_req, bus.done, bus.timeout_err}), 64'(3'b010));
        @(negedge clk);

        // Reset in the third request cycle, then a late ack.
        drive(vi(0, 1, 2'b01, 8'hE7, 4'h9, 8'h5B, 0));
        @(negedge clk);
        drive(vi(0, 0, 2'b00, 8'h00, 4'h0, 8'h00, 0));
        @(negedge clk);
        @(negedge clk);
        check("reset_pre_req", 64'({bus.mem_req, bus.mem_wdata}), 64'({1'b1, 8'hE7}));
        rst = 1'b1;
        @(negedge clk);
        check("reset_mid_drain", 64'(get_out()), 64'd0);
        rst = 1'b0;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check("late_ack_ignored", 64'(get_out()), 64'd0);
        @(negedge clk);
        check("idle_after_late_ack", 64'(get_out()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
